// File: rtl/sprite_pkg.sv
// sprite_pkg: shared constants for the multi-sprite renderer.
//   - FSM state encodings (IDLE / EVAL)
//   - write-target select codes for the CPU write port
//   - bit positions inside the per-sprite control word
//   - idx_w(): index width helper that never returns zero
package sprite_pkg;

    typedef logic [0:0] state_t;

    localparam state_t ST_IDLE = 1'b0;
    localparam state_t ST_EVAL = 1'b1;

    localparam logic [1:0] WSEL_BITMAP = 2'd0;
    localparam logic [1:0] WSEL_X      = 2'd1;
    localparam logic [1:0] WSEL_Y      = 2'd2;
    localparam logic [1:0] WSEL_CTRL   = 2'd3;

    localparam int CTRL_EN    = 0;
    localparam int CTRL_HFLIP = 1;

    // Width of an index into n items; a single item still gets one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sprite_slot.sv
// sprite_slot: one line slot of the sprite renderer.
//   Holds the bitmap row, x position, hflip and valid flag captured during
//   hblank evaluation, and decodes them against the beam x position.
// Ports:
//   clk, reset        pixel clock, async active-low reset
//   clear             invalidate the slot (start of line evaluation)
//   load, load_*      capture a new row/x/hflip and mark the slot valid
//   hpos              beam x
//   hit               slot valid and hpos inside the sprite's 8-pixel span
//   opaque            bitmap bit addressed by hpos (meaningful only with hit)
module sprite_slot
    import sprite_pkg::*;
#(
    parameter int SPR_W  = 8,
    parameter int HPOS_W = 8
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              load,
    input  logic [SPR_W-1:0]  load_row,
    input  logic [HPOS_W-1:0] load_x,
    input  logic              load_hflip,
    input  logic [HPOS_W-1:0] hpos,
    output logic              hit,
    output logic              opaque
);

    localparam int CW = idx_w(SPR_W);
    localparam logic [HPOS_W:0] SPR_W_L = (HPOS_W+1)'(SPR_W);

    logic [SPR_W-1:0]  row_q, row_d;
    logic [HPOS_W-1:0] x_q, x_d;
    logic              hflip_q, hflip_d;
    logic              valid_q, valid_d;

    logic [HPOS_W-1:0] col_s;
    logic [CW-1:0]     col_idx_s;
    logic [CW-1:0]     bit_idx_s;

    // Next-state for the slot snapshot: clear has priority over load.
    always_comb begin
        row_d   = row_q;
        x_d     = x_q;
        hflip_d = hflip_q;
        valid_d = valid_q;
        if (clear) begin
            valid_d = 1'b0;
        end else if (load) begin
            row_d   = load_row;
            x_d     = load_x;
            hflip_d = load_hflip;
            valid_d = 1'b1;
        end else begin
            valid_d = valid_q;
        end
    end

    // Slot snapshot registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_q   <= '0;
            x_q     <= '0;
            hflip_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            row_q   <= row_d;
            x_q     <= x_d;
            hflip_q <= hflip_d;
            valid_q <= valid_d;
        end
    end

    // Column decode; the modular subtraction gives horizontal wrap-around for free.
    always_comb begin
        col_s     = hpos - x_q;
        col_idx_s = col_s[CW-1:0];
        bit_idx_s = hflip_q ? (CW'(SPR_W - 1) - col_idx_s) : col_idx_s;
        hit       = valid_q && ({1'b0, col_s} < SPR_W_L);
        opaque    = row_q[bit_idx_s];
    end

endmodule

// File: rtl/sprite_engine.sv
// sprite_engine: multi-sprite renderer overlaid on the video beam.
//   CPU-writable bitmap RAM and per-sprite attributes (x, y, enable, hflip).
//   On each hsync rising edge the FSM walks the sprites, one per clk, and
//   snapshots the row needed on the next line into the line slots. The pixel
//   path only looks at the slots, so writes never disturb the current line.
// Ports:
//   clk, reset            pixel clock, async active-low reset
//   hpos, vpos            beam position
//   hsync, vsync          rising edges start line evaluation / clear collision
//   we, wsel, waddr, wdata CPU write port (bitmap row, x, y, ctrl)
//   pixel, sprite_id      registered opaque flag and winning sprite index
//   collision             sticky: two opaque sprites overlapped this frame
module sprite_engine
    import sprite_pkg::*;
#(
    parameter int NUM_SPRITES = 4,
    parameter int SPR_W       = 8,
    parameter int SPR_H       = 8,
    parameter int HPOS_W      = 8,
    parameter int VPOS_W      = 7,
    localparam int AW         = idx_w(NUM_SPRITES * SPR_H),
    localparam int IW         = idx_w(NUM_SPRITES)
)(
    input  logic              clk,
    input  logic              reset,
    input  logic [HPOS_W-1:0] hpos,
    input  logic [VPOS_W-1:0] vpos,
    input  logic              hsync,
    input  logic              vsync,
    input  logic              we,
    input  logic [1:0]        wsel,
    input  logic [AW-1:0]     waddr,
    input  logic [SPR_W-1:0]  wdata,
    output logic              pixel,
    output logic [IW-1:0]     sprite_id,
    output logic              collision
);

    localparam int DEPTH = NUM_SPRITES * SPR_H;
    localparam int RW    = idx_w(SPR_H);

    // Bitmap RAM (no reset) and attribute registers.
    logic [SPR_W-1:0]  bitmap_mem [DEPTH];
    logic [HPOS_W-1:0] x_q [NUM_SPRITES];
    logic [HPOS_W-1:0] x_d [NUM_SPRITES];
    logic [VPOS_W-1:0] y_q [NUM_SPRITES];
    logic [VPOS_W-1:0] y_d [NUM_SPRITES];
    logic [NUM_SPRITES-1:0] en_q, en_d;
    logic [NUM_SPRITES-1:0] hflip_q, hflip_d;

    state_t            state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic              hsync_q, vsync_q;
    logic              pixel_q, pixel_d;
    logic [IW-1:0]     sprite_id_q, sprite_id_d;
    logic              collision_q, collision_d;

    logic              bm_we_s, attr_ok_s;
    logic [IW-1:0]     widx_s;
    logic              hsync_rise_s, vsync_rise_s;
    logic [VPOS_W-1:0] eval_row_s;
    logic              row_ok_s;
    logic [AW-1:0]     eval_addr_s;
    logic              slot_clear_s;
    logic [NUM_SPRITES-1:0] slot_load_s;
    logic [NUM_SPRITES-1:0] hit_s, opaque_s, vis_s;
    logic              multi_s;

    // Write decode; attribute writes beyond the last sprite are dropped.
    always_comb begin
        widx_s    = waddr[IW-1:0];
        attr_ok_s = (32'(waddr) < 32'(NUM_SPRITES));
        bm_we_s   = we && (wsel == WSEL_BITMAP) && (32'(waddr) < 32'(DEPTH));
    end

    // Bitmap RAM write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (bm_we_s) begin
            bitmap_mem[waddr] <= wdata;
        end
    end

    // Attribute next-state from the CPU write port.
    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        en_d    = en_q;
        hflip_d = hflip_q;
        if (we && attr_ok_s) begin
            case (wsel)
                WSEL_X:    x_d[widx_s] = wdata[HPOS_W-1:0];
                WSEL_Y:    y_d[widx_s] = wdata[VPOS_W-1:0];
                WSEL_CTRL: begin
                    en_d[widx_s]    = wdata[CTRL_EN];
                    hflip_d[widx_s] = wdata[CTRL_HFLIP];
                end
                default:   en_d = en_q;
            endcase
        end else begin
            en_d = en_q;
        end
    end

    // Attribute registers; reset leaves every sprite disabled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                x_q[i] <= '0;
                y_q[i] <= '0;
            end
            en_q    <= '0;
            hflip_q <= '0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            en_q    <= en_d;
            hflip_q <= hflip_d;
        end
    end

    // Row lookup for the sprite under evaluation; it is drawn on line vpos+1.
    always_comb begin
        hsync_rise_s = hsync & ~hsync_q;
        vsync_rise_s = vsync & ~vsync_q;
        eval_row_s   = vpos + VPOS_W'(1) - y_q[idx_q];
        row_ok_s     = ({1'b0, eval_row_s} < (VPOS_W+1)'(SPR_H));
        eval_addr_s  = AW'(idx_q) * AW'(SPR_H) + AW'(eval_row_s[RW-1:0]);
    end

    // Line-evaluation FSM: IDLE waits for hsync, EVAL visits one sprite per clk.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        slot_clear_s = 1'b0;
        slot_load_s  = '0;
        case (state_q)
            ST_IDLE: begin
                if (hsync_rise_s) begin
                    state_d      = ST_EVAL;
                    idx_d        = '0;
                    slot_clear_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EVAL: begin
                if (en_q[idx_q] && row_ok_s) begin
                    slot_load_s[idx_q] = 1'b1;
                end else begin
                    slot_load_s = '0;
                end
                if (32'(idx_q) == 32'(NUM_SPRITES - 1)) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // FSM state and sync edge-detect registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            hsync_q <= 1'b0;
            vsync_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            hsync_q <= hsync;
            vsync_q <= vsync;
        end
    end

    for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_slot
        sprite_slot #(
            .SPR_W  (SPR_W),
            .HPOS_W (HPOS_W)
        ) u_slot (
            .clk        (clk),
            .reset      (reset),
            .clear      (slot_clear_s),
            .load       (slot_load_s[g]),
            .load_row   (bitmap_mem[eval_addr_s]),
            .load_x     (x_q[idx_q]),
            .load_hflip (hflip_q[idx_q]),
            .hpos       (hpos),
            .hit        (hit_s[g]),
            .opaque     (opaque_s[g])
        );
    end

    // Priority encode (lowest index wins) and overlap detection.
    always_comb begin
        vis_s       = hit_s & opaque_s;
        pixel_d     = 1'b0;
        sprite_id_d = '0;
        // Walk downwards so the lowest visible index is the last one written.
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            pixel_d     = pixel_d | vis_s[i];
            sprite_id_d = vis_s[i] ? IW'(i) : sprite_id_d;
        end
        // Clearing the lowest set bit leaves something only if two or more were set.
        multi_s = |(vis_s & (vis_s - NUM_SPRITES'(1)));
        if (vsync_rise_s) begin
            collision_d = 1'b0;
        end else if ((state_q == ST_IDLE) && multi_s) begin
            collision_d = 1'b1;
        end else begin
            collision_d = collision_q;
        end
    end

    // Registered video outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pixel_q     <= 1'b0;
            sprite_id_q <= '0;
            collision_q <= 1'b0;
        end else begin
            pixel_q     <= pixel_d;
            sprite_id_q <= sprite_id_d;
            collision_q <= collision_d;
        end
    end

    assign pixel     = pixel_q;
    assign sprite_id = sprite_id_q;
    assign collision = collision_q;

endmodule

// File: tb/tb_sprite_engine.sv
// tb_sprite_engine: self-checking bench for sprite_engine (default parameters).
//   Inputs change on the falling edge; each driven hpos pushes an expected
//   record to a queue that is popped one clk later, when the registered
//   outputs for that hpos are visible.
module tb_sprite_engine;

    localparam logic [7:0] PARK = 8'd200;   // no sprite ever covers this column

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] hpos;
    logic [6:0] vpos;
    logic       hsync, vsync, we;
    logic [1:0] wsel;
    logic [4:0] waddr;
    logic [7:0] wdata;
    logic       pixel;
    logic [1:0] sprite_id;
    logic       collision;

    always #5 clk = ~clk;

    sprite_engine dut (
        .clk       (clk),
        .reset     (reset),
        .hpos      (hpos),
        .vpos      (vpos),
        .hsync     (hsync),
        .vsync     (vsync),
        .we        (we),
        .wsel      (wsel),
        .waddr     (waddr),
        .wdata     (wdata),
        .pixel     (pixel),
        .sprite_id (sprite_id),
        .collision (collision)
    );

    typedef struct {
        logic [7:0] h;
        logic       pix;
        logic [1:0] id;
        logic       col;
    } exp_t;

    typedef struct {
        int         sc;
        logic [7:0] h;
        logic       pix;
        logic [1:0] id;
        logic       col;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[$];
    int   total = 0;
    int   bad   = 0;

    // Reference state: attributes as written, and slot snapshots per line.
    logic [7:0] m_bmp  [32];
    logic [7:0] m_x    [4];
    logic [6:0] m_y    [4];
    logic       m_en   [4];
    logic       m_flip [4];
    logic       s_valid[4];
    logic [7:0] s_row  [4];
    logic [7:0] s_x    [4];
    logic       s_flip [4];
    logic       m_coll = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic add(input int sc, input logic [7:0] h, input logic p, input logic [1:0] id, input logic c);
        vec_t v;
        v.sc = sc; v.h = h; v.pix = p; v.id = id; v.col = c;
        tbl.push_back(v);
    endtask

    task automatic model_px(input logic [7:0] h, output exp_t e);
        int         cnt;
        int         b;
        logic [7:0] c;
        cnt = 0; e.h = h; e.pix = 1'b0; e.id = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            c = h - s_x[i];
            if (s_valid[i] && c < 8'd8) begin
                b = s_flip[i] ? 7 - int'(c) : int'(c);
                if (s_row[i][b]) begin
                    cnt++;
                    e.pix = 1'b1;
                    e.id  = 2'(i);
                end
            end
        end
        if (cnt >= 2) m_coll = 1'b1;
        e.col = m_coll;
    endtask

    task automatic pop_check();
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk($sformatf("pixel@h%0d", e.h), 32'(pixel), 32'(e.pix));
            chk($sformatf("id@h%0d", e.h), 32'(sprite_id), 32'(e.id));
            chk($sformatf("coll@h%0d", e.h), 32'(collision), 32'(e.col));
        end
    endtask

    task automatic cyc(input logic [7:0] h);
        exp_t e;
        @(negedge clk);
        pop_check();
        we   = 1'b0;
        hpos = h;
        model_px(h, e);
        sb.push_back(e);
    endtask

    task automatic sweep(input int lo, input int hi);
        for (int h = lo; h <= hi; h++) cyc(8'(h));
    endtask

    task automatic run_tbl(input int sc);
        exp_t e, m;
        foreach (tbl[k]) begin
            if (tbl[k].sc == sc) begin
                @(negedge clk);
                pop_check();
                we   = 1'b0;
                hpos = tbl[k].h;
                model_px(tbl[k].h, m);
                e.h = tbl[k].h; e.pix = tbl[k].pix; e.id = tbl[k].id; e.col = tbl[k].col;
                sb.push_back(e);
            end
        end
    endtask

    task automatic drain();
        @(negedge clk);
        pop_check();
        we   = 1'b0;
        hpos = PARK;
    endtask

    task automatic wr(input logic [1:0] sel, input logic [4:0] addr, input logic [7:0] data);
        cyc(hpos);
        we = 1'b1; wsel = sel; waddr = addr; wdata = data;
        case (sel)
            2'd0: m_bmp[addr] = data;
            2'd1: m_x[addr[1:0]] = data;
            2'd2: m_y[addr[1:0]] = data[6:0];
            default: begin
                m_en[addr[1:0]]   = data[0];
                m_flip[addr[1:0]] = data[1];
            end
        endcase
    endtask

    task automatic snapshot(input logic [6:0] v);
        logic [6:0] r;
        for (int i = 0; i < 4; i++) begin
            r          = v + 7'd1 - m_y[i];
            s_valid[i] = m_en[i] && (r < 7'd8);
            s_row[i]   = m_bmp[i * 8 + int'(r[2:0])];
            s_x[i]     = m_x[i];
            s_flip[i]  = m_flip[i];
        end
    endtask

    // Evaluate sprites on line v, leaving the beam on line v+1.
    task automatic line_eval(input logic [6:0] v);
        cyc(PARK);
        vpos = v; hsync = 1'b0;
        cyc(PARK);
        hsync = 1'b1;
        snapshot(v);
        repeat (6) cyc(PARK);
        hsync = 1'b0;
        vpos  = v + 7'd1;
    endtask

    task automatic vs_pulse();
        exp_t e;
        @(negedge clk);
        pop_check();
        we = 1'b0; hpos = PARK; vsync = 1'b1; m_coll = 1'b0;
        model_px(PARK, e);
        sb.push_back(e);
        cyc(PARK);
        vsync = 1'b0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_x[i] = 8'd0; m_y[i] = 7'd0; m_en[i] = 1'b0; m_flip[i] = 1'b0;
            s_valid[i] = 1'b0; s_row[i] = 8'd0; s_x[i] = 8'd0; s_flip[i] = 1'b0;
        end
        m_coll = 1'b0;
    endtask

    initial begin
        // Hand-derived spot vectors {scenario, hpos, pixel, sprite_id, collision}.
        add(1, 8'd9, 1'b0, 2'd0, 1'b0);   add(1, 8'd10, 1'b1, 2'd0, 1'b0);
        add(1, 8'd11, 1'b0, 2'd0, 1'b0);  add(1, 8'd17, 1'b0, 2'd0, 1'b0);
        add(2, 8'd10, 1'b0, 2'd0, 1'b0);  add(2, 8'd16, 1'b0, 2'd0, 1'b0);
        add(2, 8'd17, 1'b1, 2'd0, 1'b0);  add(2, 8'd18, 1'b0, 2'd0, 1'b0);
        for (int h = 38; h <= 53; h++) begin
            if (h < 40)      add(3, 8'(h), 1'b0, 2'd0, 1'b0);
            else if (h < 44) add(3, 8'(h), 1'b1, 2'd0, 1'b0);
            else if (h < 48) add(3, 8'(h), 1'b1, 2'd0, 1'b1);
            else if (h < 52) add(3, 8'(h), 1'b1, 2'd1, 1'b1);
            else             add(3, 8'(h), 1'b0, 2'd0, 1'b1);
        end
        add(4, 8'd250, 1'b0, 2'd0, 1'b0); add(4, 8'd251, 1'b0, 2'd0, 1'b0);
        add(4, 8'd252, 1'b1, 2'd0, 1'b0); add(4, 8'd255, 1'b1, 2'd0, 1'b0);
        add(4, 8'd0, 1'b1, 2'd0, 1'b0);   add(4, 8'd3, 1'b1, 2'd0, 1'b0);
        add(4, 8'd4, 1'b0, 2'd0, 1'b0);
        add(5, 8'd252, 1'b0, 2'd0, 1'b0); add(5, 8'd0, 1'b0, 2'd0, 1'b0);
        add(6, 8'd104, 1'b1, 2'd0, 1'b0); add(6, 8'd120, 1'b0, 2'd0, 1'b0);
        add(7, 8'd104, 1'b0, 2'd0, 1'b0); add(7, 8'd120, 1'b1, 2'd0, 1'b0);
        add(8, 8'd10, 1'b0, 2'd0, 1'b0);
        add(9, 8'd17, 1'b1, 2'd0, 1'b0);  add(9, 8'd18, 1'b0, 2'd0, 1'b0);

        for (int i = 0; i < 32; i++) m_bmp[i] = 8'd0;
        model_reset();
        reset = 1'b0; hpos = PARK; vpos = 7'd0; hsync = 1'b0; vsync = 1'b0;
        we = 1'b0; wsel = 2'd0; waddr = 5'd0; wdata = 8'd0;
        repeat (3) @(negedge clk);
        chk("reset_pixel", 32'(pixel), 32'd0);
        chk("reset_id", 32'(sprite_id), 32'd0);
        chk("reset_coll", 32'(collision), 32'd0);
        reset = 1'b1;

        // Bitmaps for every sprite are written so the model never reads unknowns.
        for (int r = 0; r < 8; r++) wr(2'd0, 5'(r), 8'h01 << r);
        for (int a = 8; a < 32; a++) wr(2'd0, 5'(a), 8'hFF);
        wr(2'd1, 5'd0, 8'd10); wr(2'd2, 5'd0, 8'd20); wr(2'd3, 5'd0, 8'd1);

        // Single sprite, no flip.
        line_eval(7'd19);
        sweep(0, 40); run_tbl(1);

        // Horizontal flip.
        wr(2'd3, 5'd0, 8'd3);
        line_eval(7'd19);
        sweep(0, 40); run_tbl(2);

        // Two solid overlapping sprites: priority and sticky collision.
        wr(2'd0, 5'd0, 8'hFF); wr(2'd3, 5'd0, 8'd1); wr(2'd1, 5'd0, 8'd40);
        wr(2'd1, 5'd1, 8'd44); wr(2'd2, 5'd1, 8'd20); wr(2'd3, 5'd1, 8'd1);
        line_eval(7'd19);
        run_tbl(3);
        repeat (3) cyc(PARK);
        vs_pulse();
        repeat (2) cyc(PARK);

        // Horizontal wrap at x=252, then the same sprite disabled.
        wr(2'd3, 5'd1, 8'd0); wr(2'd1, 5'd0, 8'd252);
        line_eval(7'd19);
        run_tbl(4); sweep(0, 255);
        wr(2'd3, 5'd0, 8'd0);
        line_eval(7'd19);
        run_tbl(5); sweep(0, 255);

        // Mid-line x rewrite is only seen on the next line.
        wr(2'd3, 5'd0, 8'd1); wr(2'd1, 5'd0, 8'd100);
        line_eval(7'd19);
        sweep(90, 99);
        wr(2'd1, 5'd0, 8'd120);
        sweep(100, 130); run_tbl(6);
        line_eval(7'd19);
        run_tbl(7); sweep(95, 130);

        // Reset in the middle of EVAL while the pixel output is high.
        wr(2'd1, 5'd0, 8'd10);
        line_eval(7'd19);
        drain();
        @(negedge clk);
        hpos = 8'd10; vpos = 7'd19; hsync = 1'b0;
        @(negedge clk);
        hsync = 1'b1;
        chk("pre_reset_pixel", 32'(pixel), 32'd1);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("midreset_pixel", 32'(pixel), 32'd0);
        chk("midreset_id", 32'(sprite_id), 32'd0);
        chk("midreset_coll", 32'(collision), 32'd0);
        model_reset();
        @(negedge clk);
        hsync = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1; hpos = PARK; vpos = 7'd20;
        sweep(0, 31); run_tbl(8);
        wr(2'd1, 5'd0, 8'd10); wr(2'd2, 5'd0, 8'd20); wr(2'd3, 5'd0, 8'd1);
        line_eval(7'd19);
        sweep(0, 31); run_tbl(9);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
